// File: rtl/output_port_allocator_if.sv
// Switch-allocator bundle for one router output port: the input-side
// requests and flit qualifiers, the grant/occupancy status returned to the
// inputs, and the credit status of the downstream link.
interface output_port_allocator_if #(
  parameter int PORTS = 5,
  parameter int ID_W  = 3,
  parameter int CW    = 3
);
  logic [PORTS-1:0] req;
  logic [PORTS-1:0] flit_valid;
  logic [PORTS-1:0] flit_tail;
  logic             credit_in;
  logic [PORTS-1:0] grant;
  logic [0:3]       occupied;   // occupied[0]=busy, occupied[1:3]=owner id MSB-first
  logic [ID_W-1:0]  sel_id;
  logic [PORTS-1:0] pop;
  logic             out_valid;
  logic [CW-1:0]    credit_cnt;
  logic             credit_err;

  // Input ports / stimulus side
  modport master (
    output req, flit_valid, flit_tail, credit_in,
    input  grant, occupied, sel_id, pop, out_valid, credit_cnt, credit_err
  );

  // Allocator side
  modport slave (
    input  req, flit_valid, flit_tail, credit_in,
    output grant, occupied, sel_id, pop, out_valid, credit_cnt, credit_err
  );
endinterface

// File: rtl/output_port_allocator.sv
// Per-output-port wormhole switch allocator. A round-robin search picks one
// requesting input while idle; that input then owns the output until its
// tail flit crosses. Flit transfer is gated by downstream credits.
module output_port_allocator #(
  parameter int PORTS   = 5,
  parameter int ID_W    = 3,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output_port_allocator_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  sel_q,   sel_d;
  logic [ID_W-1:0]  rr_q,    rr_d;
  logic [0:3]       occ_q,   occ_d;
  logic [CW-1:0]    cred_q,  cred_d;
  logic             err_q,   err_d;

  logic             found_s;
  logic [ID_W-1:0]  pick_s;
  logic             fire_s;
  logic             tail_s;

  // Rotating-priority search: first requester at or after the rr pointer.
  // Walking the offsets downwards lets the nearest requester overwrite others.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_sel;
    found_s = 1'b0;
    pick_s  = '0;
    idx     = 0;
    idx_sel = '0;
    for (int k = PORTS - 1; k >= 0; k--) begin
      idx     = (int'(rr_q) + k) % PORTS;
      idx_sel = ID_W'(idx);
      if (bus.req[idx_sel]) begin
        found_s = 1'b1;
        pick_s  = idx_sel;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Transfer qualification: only the owner's flit may cross, and only with a credit.
  always_comb begin
    fire_s = 1'b0;
    tail_s = 1'b0;
    if (state_q == BUSY) begin
      fire_s = bus.flit_valid[sel_q] & (cred_q != {CW{1'b0}});
      tail_s = bus.flit_tail[sel_q];
    end else begin
      fire_s = 1'b0;
      tail_s = 1'b0;
    end
  end

  // Ownership FSM: grant on a request while idle, release on the tail transfer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    occ_d   = occ_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BUSY;
          grant_d = {{(PORTS-1){1'b0}}, 1'b1} << pick_s;
          sel_d   = pick_s;
          occ_d   = {1'b1, 3'(pick_s)};
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (fire_s && tail_s) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = '0;
          occ_d   = 4'b0000;
          if (sel_q == ID_W'(PORTS - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = sel_q + {{(ID_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        occ_d   = 4'b0000;
      end
    endcase
  end

  // Credit bookkeeping: +1 on a returned credit, -1 on a transfer, saturate and flag overflow.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    case ({bus.credit_in, fire_s})
      2'b10: begin
        if (cred_q == CW'(CREDITS)) begin
          err_d = 1'b1;
        end else begin
          cred_d = cred_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      2'b01:   cred_d = cred_q - {{(CW-1){1'b0}}, 1'b1};
      default: cred_d = cred_q;
    endcase
  end

  // State and status registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      rr_q    <= '0;
      occ_q   <= 4'b0000;
      cred_q  <= CW'(CREDITS);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      occ_q   <= occ_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sel_id     = sel_q;
  assign bus.occupied   = occ_q;
  assign bus.credit_cnt = cred_q;
  assign bus.credit_err = err_q;
  assign bus.pop        = fire_s ? grant_q : '0;
  assign bus.out_valid  = fire_s;

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: a directed vector table,
// hand-written corner sequences and random traffic against a packet-level model.
module tb_output_port_allocator;

  localparam int P       = 5;
  localparam int ID_W    = 3;
  localparam int CREDITS = 4;
  localparam int CW      = 3;

  logic clk;
  logic rst_n;

  output_port_allocator_if #(.PORTS(P), .ID_W(ID_W), .CW(CW)) bus ();

  output_port_allocator #(.PORTS(P), .ID_W(ID_W), .CREDITS(CREDITS), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the port, where the search starts, credits held.
  int m_owner;
  int m_rr;
  int m_cred;
  bit m_err;

  typedef struct {
    logic [4:0] req;
    logic [4:0] fv;
    logic [4:0] ft;
    logic       ci;
    logic [4:0] e_grant;
    logic [3:0] e_occ;
    logic [4:0] e_pop;
    logic       e_ov;
    int         e_cred;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_fire(input logic [P-1:0] fv);
    return (m_owner >= 0) && fv[m_owner] && (m_cred > 0);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_cred  = CREDITS;
    m_err   = 1'b0;
  endtask

  task automatic model_update(input logic [P-1:0] rq, input logic [P-1:0] fv,
                              input logic [P-1:0] ft, input logic ci);
    bit f;
    f = m_fire(fv);
    if (m_owner < 0) begin
      for (int k = 0; k < P; k++) begin
        if (rq[(m_rr + k) % P]) begin
          m_owner = (m_rr + k) % P;
          break;
        end
      end
    end else if (f && ft[m_owner]) begin
      m_rr    = (m_owner + 1) % P;
      m_owner = -1;
    end
    m_cred = m_cred + int'(ci) - int'(f);
    if (m_cred > CREDITS) begin
      m_cred = CREDITS;
      m_err  = 1'b1;
    end
  endtask

  task automatic check_model();
    int eg;
    bit f;
    f  = m_fire(bus.flit_valid);
    eg = (m_owner < 0) ? 0 : (1 << m_owner);
    chk("grant",      int'(bus.grant),      eg);
    chk("occupied",   int'(bus.occupied),   (m_owner < 0) ? 0 : (8 | m_owner));
    chk("sel_id",     int'(bus.sel_id),     (m_owner < 0) ? 0 : m_owner);
    chk("pop",        int'(bus.pop),        f ? eg : 0);
    chk("out_valid",  int'(bus.out_valid),  int'(f));
    chk("credit_cnt", int'(bus.credit_cnt), m_cred);
    chk("credit_err", int'(bus.credit_err), int'(m_err));
  endtask

  // Drive inputs, then compare against the model away from the active edge.
  task automatic tick_pre(input logic [P-1:0] rq, input logic [P-1:0] fv,
                          input logic [P-1:0] ft, input logic ci);
    bus.req        = rq;
    bus.flit_valid = fv;
    bus.flit_tail  = ft;
    bus.credit_in  = ci;
    @(negedge clk);
    check_model();
  endtask

  task automatic tick_post();
    @(posedge clk);
    model_update(bus.req, bus.flit_valid, bus.flit_tail, bus.credit_in);
    #1;
  endtask

  task automatic step(input logic [P-1:0] rq, input logic [P-1:0] fv,
                      input logic [P-1:0] ft, input logic ci);
    tick_pre(rq, fv, ft, ci);
    tick_post();
  endtask

  task automatic do_reset();
    bus.req        = '0;
    bus.flit_valid = '0;
    bus.flit_tail  = '0;
    bus.credit_in  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.flit_valid = '0;
    bus.flit_tail  = '0;
    bus.credit_in  = 1'b0;

    // Directed vectors: 3-flit packet from port 2, then port 1 with lock and credit cases.
    tbl[0] = '{5'b00100, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b0000, 5'b00000, 1'b0, 4};
    tbl[1] = '{5'b00000, 5'b00100, 5'b00000, 1'b0, 5'b00100, 4'b1010, 5'b00100, 1'b1, 4};
    tbl[2] = '{5'b00000, 5'b00100, 5'b00000, 1'b0, 5'b00100, 4'b1010, 5'b00100, 1'b1, 3};
    tbl[3] = '{5'b00000, 5'b00100, 5'b00100, 1'b0, 5'b00100, 4'b1010, 5'b00100, 1'b1, 2};
    tbl[4] = '{5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b0000, 5'b00000, 1'b0, 1};
    tbl[5] = '{5'b00001, 5'b00011, 5'b00000, 1'b1, 5'b00010, 4'b1001, 5'b00010, 1'b1, 1};
    tbl[6] = '{5'b00001, 5'b00001, 5'b00000, 1'b1, 5'b00010, 4'b1001, 5'b00000, 1'b0, 1};
    tbl[7] = '{5'b00001, 5'b00011, 5'b00000, 1'b1, 5'b00010, 4'b1001, 5'b00010, 1'b1, 2};
    tbl[8] = '{5'b00001, 5'b00011, 5'b00011, 1'b0, 5'b00010, 4'b1001, 5'b00010, 1'b1, 2};
    tbl[9] = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 4'b0000, 5'b00000, 1'b0, 1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_grant",      int'(bus.grant),      0);
    chk("rst_occupied",   int'(bus.occupied),   0);
    chk("rst_sel_id",     int'(bus.sel_id),     0);
    chk("rst_credit_cnt", int'(bus.credit_cnt), CREDITS);
    chk("rst_credit_err", int'(bus.credit_err), 0);
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      bus.req        = tbl[i].req;
      bus.flit_valid = tbl[i].fv;
      bus.flit_tail  = tbl[i].ft;
      bus.credit_in  = tbl[i].ci;
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i),     int'(bus.grant),      int'(tbl[i].e_grant));
      chk($sformatf("vec%0d_occupied", i),  int'(bus.occupied),   int'(tbl[i].e_occ));
      chk($sformatf("vec%0d_pop", i),       int'(bus.pop),        int'(tbl[i].e_pop));
      chk($sformatf("vec%0d_out_valid", i), int'(bus.out_valid),  int'(tbl[i].e_ov));
      chk($sformatf("vec%0d_credit", i),    int'(bus.credit_cnt), tbl[i].e_cred);
      @(posedge clk);
      #1;
    end
    chk("vec_no_err", int'(bus.credit_err), 0);

    // Round-robin with single-flit packets: owners 0,1,2,3,4,0 with a bubble between
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick_pre(5'b11111, 5'b11111, 5'b11111, (c % 2) == 1);
      chk("rr_grant", int'(bus.grant), ((c % 2) == 1) ? (1 << ((c / 2) % P)) : 0);
      tick_post();
    end

    // Credit stall: 6-flit packet from port 0 with only two returned credits
    do_reset();
    step(5'b00001, 5'b00000, 5'b00000, 1'b0);
    repeat (4) step(5'b00000, 5'b00001, 5'b00000, 1'b0);
    for (int s = 0; s < 2; s++) begin
      tick_pre(5'b00000, 5'b00001, 5'b00000, 1'b0);
      chk("stall_out_valid", int'(bus.out_valid),  0);
      chk("stall_credit",    int'(bus.credit_cnt), 0);
      tick_post();
    end
    step(5'b00000, 5'b00001, 5'b00000, 1'b1);
    step(5'b00000, 5'b00001, 5'b00000, 1'b0);
    step(5'b00000, 5'b00001, 5'b00001, 1'b1);
    step(5'b00000, 5'b00001, 5'b00001, 1'b0);
    tick_pre(5'b00000, 5'b00000, 5'b00000, 1'b0);
    chk("stall_released", int'(bus.occupied), 0);
    tick_post();

    // Credit overflow is saturated and sticky
    do_reset();
    step(5'b00000, 5'b00000, 5'b00000, 1'b1);
    for (int s = 0; s < 3; s++) begin
      tick_pre(5'b00000, 5'b00000, 5'b00000, 1'b0);
      chk("ovf_err",    int'(bus.credit_err), 1);
      chk("ovf_credit", int'(bus.credit_cnt), CREDITS);
      tick_post();
    end

    // Wormhole lock, then pointer-ordered hand-off to port 2
    do_reset();
    step(5'b00010, 5'b00000, 5'b00000, 1'b0);
    tick_pre(5'b00001, 5'b00011, 5'b00000, 1'b0);
    chk("lock_pop", int'(bus.pop), 2);
    tick_post();
    step(5'b11101, 5'b00011, 5'b00010, 1'b0);
    step(5'b10101, 5'b00001, 5'b00000, 1'b0);
    tick_pre(5'b00000, 5'b00000, 5'b00000, 1'b0);
    chk("lock_next", int'(bus.grant), 4);
    tick_post();

    // Asynchronous reset mid-packet clears outputs without a clock edge
    do_reset();
    step(5'b00100, 5'b00000, 5'b00000, 1'b0);
    step(5'b00000, 5'b00100, 5'b00000, 1'b0);
    bus.flit_valid = 5'b00100;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant",     int'(bus.grant),      0);
    chk("arst_occupied",  int'(bus.occupied),   0);
    chk("arst_sel_id",    int'(bus.sel_id),     0);
    chk("arst_pop",       int'(bus.pop),        0);
    chk("arst_out_valid", int'(bus.out_valid),  0);
    chk("arst_credit",    int'(bus.credit_cnt), CREDITS);
    do_reset();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      step(P'($urandom & $urandom), P'($urandom), P'($urandom & $urandom),
           $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port switch allocator for the NoC router; one instance per output port.
- Each input port's priority/route stage raises a request when its head flit routes to this output. The allocator grants one input with wormhole locking: the grant is held from head flit to tail flit.
- Publishes the 4-bit occupancy word {busy, owner id} consumed by the input-side priority logic.
- Tracks downstream buffer credits and gates flit transfer on credit availability.

Parameters:
- PORTS, 5, number of router input ports (local, N, E, S, W); legal range 2..8.
- ID_W, 3, input port id width (matches LOG_PORTS_CNT).
- CREDITS, 4, downstream buffer depth in flits; also the credit reset value.
- CW, 3, credit counter width; must hold CREDITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  PORTS  req[i]=1: input i presents a head flit routed to this output.
- flit_valid  input  PORTS  input i presents a valid flit (head, body or tail).
- flit_tail  input  PORTS  qualifies flit_valid[i]; the flit is the packet tail.
- credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
- grant  output  PORTS  registered one-hot owner vector; all zero when idle.
- occupied  output  4  occupied[0]=busy; occupied[1:3]=owner id, MSB-first.
- sel_id  output  ID_W  owner id, which drives the crossbar mux select; 0 when idle.
- pop  output  PORTS  combinational one-hot transfer strobe to the owner's input buffer.
- out_valid  output  1  combinational: a flit crosses to the output link this cycle.
- credit_cnt  output  CW  current downstream credits.
- credit_err  output  1  sticky credit-overflow flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant=0, occupied=4'b0000, sel_id=0, rr pointer=0, credit_cnt=CREDITS, credit_err=0. pop and out_valid are forced to 0 while in reset.
- Reset mid-packet aborts the packet silently. No partial-packet recovery is performed.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any req[i] is set, select the first requester at or after rr pointer, wrapping modulo PORTS. Lowest index wins among ties relative to the pointer.
  - At the next clock edge: grant=onehot(i), sel_id=i, occupied={1,i}, state=BUSY.
  - Arbitration latency is exactly 1 cycle (req sampled at edge N, grant visible after edge N).
  - No transfer occurs in IDLE.
  - Granting does not require credits.
- BUSY:
  - fire = flit_valid[owner] & (credit_cnt != 0).
  - pop = fire ? grant : 0; out_valid = fire.
  - req and flit_valid from non-owners are ignored (wormhole lock).
  - fire & flit_tail[owner]: at the edge, state=IDLE, grant=0, occupied=0, sel_id=0, rr pointer=(owner+1) mod PORTS.
  - A new grant needs one further IDLE cycle, so there is one bubble cycle between packets.
  - A single-flit packet (head is also tail) releases on its first fire.
- Credits:
  - Each edge: credit_cnt += credit_in - fire.
  - Simultaneous fire and credit_in leave the count unchanged.
  - fire cannot occur at 0, so there is no underflow.
  - credit_in while credit_cnt==CREDITS with no fire: count saturates at CREDITS and credit_err is set. It stays set until reset.
- Request indices >= PORTS do not exist; no width beyond PORTS is decoded.
- The rr pointer changes only on release; it is unchanged while BUSY.
- All outputs except pop and out_valid are registered.

Test Plan:
- Reset then idle: hold rst_n=0, then release with no req → grant=0, occupied=0000, credit_cnt=4, credit_err=0; assert rst_n=0 mid-cycle → outputs clear without waiting for a clock edge.
- Single request, 3-flit packet: req[2]=1 at cycle 0 → cycle 1 grant=00100, occupied={1,010}. Three valid flits, the last with tail → pop[2] asserted 3 cycles, credit_cnt 4→1, then occupied=0000.
- Round-robin: req=11111 held continuously, single-flit packets → owner sequence 0,1,2,3,4,0, with one idle cycle between grants.
- Credit stall: CREDITS=4, owner streams 6-flit packet with no credit_in → 4 fires then stall (out_valid=0, credit_cnt=0). Pulse credit_in twice → 2 more fires, tail releases.
- Simultaneous fire and credit_in at credit_cnt=2 → count stays 2. Extra credit_in at credit_cnt=4 with no fire → count stays 4, credit_err=1 and sticky.
- Lock check: owner 1 mid-packet, req[0]=1 and flit_valid[0]=1 asserted → pop[0] never asserted. After tail of port 1, next grant goes to port 0 only if ports 2..4 are not requesting (pointer=2 search order 2,3,4,0).
